// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - pipeline enable/flush sequencing with memory-freeze FSM
//
// Purpose:
//   Central sequencing controller for the 5-stage core. Converts hazard,
//   taken-branch and data-memory handshake information into per-stage
//   register enables and flushes. Multi-cycle memory accesses freeze the
//   whole pipeline; an access that never completes within MEM_TIMEOUT
//   wait cycles parks the controller in a sticky error state.
//   Stall, flush and freeze cycles are counted for performance debug.
//
// Parameters:
//   MEM_TIMEOUT  max consecutive MEM_WAIT cycles before memory error
//   CNT_W        width of the performance counters
//
// Ports:
//   clk              pipeline clock, rising edge
//   rst              asynchronous active-high reset
//   hazard_detected  ID instruction must wait
//   branch_taken     EXE-stage taken branch/jump (IF/ID are wrong-path)
//   mem_req          MEM stage has a load/store in flight
//   mem_ready        data memory completes the access this cycle
//   cnt_clr          synchronous clear of the three counters
//   pc_en            PC load enable
//   if_id_en         IF/ID enable
//   if_id_flush      IF/ID loads a NOP
//   id_exe_en        ID/EXE enable
//   id_exe_flush     ID/EXE loads a bubble
//   exe_mem_en       EXE/MEM enable
//   mem_wb_en        MEM/WB enable
//   mem_error        sticky memory-timeout flag
//   stall_cnt        hazard-stall cycle count
//   flush_cnt        branch-flush cycle count
//   freeze_cnt       memory-freeze cycle count

module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_exe_en,
  output logic             id_exe_flush,
  output logic             exe_mem_en,
  output logic             mem_wb_en,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;

  // Which action is applied this cycle; these also drive the counters.
  logic freeze_act;
  logic flush_act;
  logic stall_act;

  // ---------------------------------------------------------------------
  // Action decode: freeze > flush > stall > normal.
  // In ERROR nothing is "applied": the pipeline is dead, not frozen, so
  // no counter advances there.
  // ---------------------------------------------------------------------
  always_comb begin
    freeze_act = 1'b0;
    flush_act  = 1'b0;
    stall_act  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_RUN:      freeze_act = mem_req && !mem_ready;
        ST_MEM_WAIT: freeze_act = !mem_ready;
        default:     freeze_act = 1'b0;
      endcase
      if (state_q != ST_ERROR && !freeze_act) begin
        flush_act = branch_taken;
        // A hazard under a taken branch is squashed along with the branch shadow.
        stall_act = !branch_taken && hazard_detected;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage controls. Everything defaults to "hold, no flush", which is
  // exactly the freeze / ERROR / reset behaviour.
  // ---------------------------------------------------------------------
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_exe_en    = 1'b0;
    id_exe_flush = 1'b0;
    exe_mem_en   = 1'b0;
    mem_wb_en    = 1'b0;
    if (!rst && state_q != ST_ERROR && !freeze_act) begin
      exe_mem_en = 1'b1;
      mem_wb_en  = 1'b1;
      id_exe_en  = 1'b1;
      if (flush_act) begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b1;
        id_exe_flush = 1'b1;
      end else if (stall_act) begin
        // Hold PC and IF/ID, push a bubble into ID/EXE.
        id_exe_flush = 1'b1;
      end else begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Memory-freeze FSM, next state.
  // The wait counter holds the index of the current MEM_WAIT cycle, so the
  // access gets exactly MEM_TIMEOUT wait cycles after the first frozen RUN
  // cycle before giving up.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          state_d    = ST_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      mem_error  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (state_d == ST_ERROR) begin
        mem_error <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Saturating performance counters; clear beats increment.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (stall_act && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush_act && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
      if (freeze_act && freeze_cnt != '1) begin
        freeze_cnt <= freeze_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - self-checking bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

  localparam int T    = 4;
  localparam int W    = 4;
  localparam int CMAX = (1 << W) - 1;

  localparam logic [6:0] C_NORM   = 7'b1101011;
  localparam logic [6:0] C_STALL  = 7'b0001111;
  localparam logic [6:0] C_FLUSH  = 7'b1111111;
  localparam logic [6:0] C_FREEZE = 7'b0000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, hazard_detected, branch_taken, mem_req, mem_ready, cnt_clr;
  logic pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_flush, exe_mem_en, mem_wb_en;
  logic mem_error;
  logic [W-1:0] stall_cnt, flush_cnt, freeze_cnt;

  pipeline_stall_ctrl #(.MEM_TIMEOUT(T), .CNT_W(W)) dut (
    .clk(clk), .rst(rst),
    .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_exe_en(id_exe_en), .id_exe_flush(id_exe_flush),
    .exe_mem_en(exe_mem_en), .mem_wb_en(mem_wb_en),
    .mem_error(mem_error),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: counts consecutive frozen cycles of the current access.
  int m_w;
  bit m_err;
  int m_sc, m_fc, m_zc;

  typedef struct {
    logic       hz;
    logic       br;
    logic       req;
    logic       rdy;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_freeze(input logic req, input logic rdy);
    if (m_err) return 1'b0;
    return (m_w > 0) ? !rdy : (req && !rdy);
  endfunction

  function automatic logic [6:0] model_ctrl(input logic r, input logic hz, input logic br,
                                            input logic req, input logic rdy);
    if (r || m_err) return C_FREEZE;
    if (model_freeze(req, rdy)) return C_FREEZE;
    if (br) return C_FLUSH;
    if (hz) return C_STALL;
    return C_NORM;
  endfunction

  task automatic model_reset();
    m_w = 0; m_err = 0; m_sc = 0; m_fc = 0; m_zc = 0;
  endtask

  task automatic model_step(input logic hz, input logic br, input logic req,
                            input logic rdy, input logic clr);
    bit fr, fl, st;
    fr = model_freeze(req, rdy);
    fl = !m_err && !fr && br;
    st = !m_err && !fr && !br && hz;
    if (clr) begin
      m_sc = 0; m_fc = 0; m_zc = 0;
    end else begin
      if (st) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
      if (fl) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
      if (fr) m_zc = (m_zc < CMAX) ? m_zc + 1 : CMAX;
    end
    if (!m_err) begin
      if (fr) begin
        m_w++;
        if (m_w == T + 1) m_err = 1;
      end else begin
        m_w = 0;
      end
    end
  endtask

  function automatic logic [6:0] dut_ctrl();
    return {pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_flush, exe_mem_en, mem_wb_en};
  endfunction

  // One clock cycle: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic cycle(input logic r, input logic hz, input logic br, input logic req,
                       input logic rdy, input logic clr, input logic [7:0] tbl_exp);
    rst = r; hazard_detected = hz; branch_taken = br;
    mem_req = req; mem_ready = rdy; cnt_clr = clr;
    if (r) model_reset();
    @(negedge clk);
    check("ctrl", int'(dut_ctrl()), int'(model_ctrl(r, hz, br, req, rdy)));
    if (tbl_exp[7]) check("tbl_ctrl", int'(dut_ctrl()), int'(tbl_exp[6:0]));
    check("stall_cnt", int'(stall_cnt), m_sc);
    check("flush_cnt", int'(flush_cnt), m_fc);
    check("freeze_cnt", int'(freeze_cnt), m_zc);
    check("mem_error", int'(mem_error), int'(m_err));
    @(posedge clk);
    if (!r) model_step(hz, br, req, rdy, clr);
    #1;
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    rst = 1; hazard_detected = 0; branch_taken = 0;
    mem_req = 0; mem_ready = 0; cnt_clr = 0;
    model_reset();

    tbl[0] = '{0, 0, 0, 0, C_NORM};
    tbl[1] = '{1, 0, 0, 0, C_STALL};
    tbl[2] = '{0, 1, 0, 0, C_FLUSH};
    tbl[3] = '{1, 1, 0, 0, C_FLUSH};
    tbl[4] = '{0, 0, 1, 0, C_FREEZE};
    tbl[5] = '{1, 1, 1, 0, C_FREEZE};
    tbl[6] = '{0, 0, 1, 1, C_NORM};
    tbl[7] = '{1, 0, 1, 1, C_STALL};
    tbl[8] = '{0, 1, 1, 1, C_FLUSH};
    tbl[9] = '{0, 0, 0, 1, C_NORM};

    // Reset state: controls all low while rst is high, counters zero.
    do_reset();

    // Single-cycle decode table from a fresh RUN state.
    for (int i = 0; i < 10; i++) begin
      do_reset();
      cycle(0, tbl[i].hz, tbl[i].br, tbl[i].req, tbl[i].rdy, 0, {1'b1, tbl[i].exp});
    end

    // Hazard stall for two cycles.
    do_reset();
    cycle(0, 1, 0, 0, 0, 0, {1'b1, C_STALL});
    cycle(0, 1, 0, 0, 0, 0, {1'b1, C_STALL});
    check("seq_stall_cnt", int'(stall_cnt), 2);

    // Branch and hazard together: flush wins.
    do_reset();
    cycle(0, 1, 1, 0, 0, 0, {1'b1, C_FLUSH});
    check("seq_bh_flush", int'(flush_cnt), 1);
    check("seq_bh_stall", int'(stall_cnt), 0);

    // Three-cycle memory wait under a held branch, then flush on completion.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 0, 0, {1'b1, C_FREEZE});
    cycle(0, 0, 1, 1, 1, 0, {1'b1, C_FLUSH});
    check("seq_mw_freeze", int'(freeze_cnt), 3);
    check("seq_mw_flush", int'(flush_cnt), 1);

    // Timeout: five frozen cycles, then sticky error; async reset clears it.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 0, {1'b1, C_FREEZE});
    check("seq_to_noerr_yet", int'(mem_error), 0);
    cycle(0, 0, 0, 1, 0, 0, {1'b1, C_FREEZE});
    check("seq_to_freeze", int'(freeze_cnt), 5);
    check("seq_to_err", int'(mem_error), 1);
    cycle(0, 1, 1, 0, 1, 0, {1'b1, C_FREEZE});
    cycle(0, 0, 0, 1, 1, 0, {1'b1, C_FREEZE});
    check("seq_to_freeze_hold", int'(freeze_cnt), 5);
    rst = 1;
    #2;
    check("seq_async_err", int'(mem_error), 0);
    check("seq_async_freeze", int'(freeze_cnt), 0);
    check("seq_async_ctrl", int'(dut_ctrl()), int'(C_FREEZE));
    model_reset();
    do_reset();

    // Saturation at 15, then clear beats increment.
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0, 0, 0, {1'b1, C_STALL});
    check("seq_sat", int'(stall_cnt), CMAX);
    cycle(0, 1, 0, 0, 0, 1, {1'b1, C_STALL});
    check("seq_clr", int'(stall_cnt), 0);

    // Zero-wait memory: no freeze, stays in RUN.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 1, 0, {1'b1, C_NORM});
    check("seq_zw_freeze", int'(freeze_cnt), 0);
    cycle(0, 0, 0, 0, 0, 0, {1'b1, C_NORM});

    // Randomized stimulus against the reference model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(99) == 0),
            ($urandom_range(2) == 0),
            ($urandom_range(3) == 0),
            ($urandom_range(1) == 0),
            ($urandom_range(2) == 0),
            ($urandom_range(19) == 0),
            8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
